regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the single-cycle/next-gen datapath.
- Configurable width, depth and read-port count; two write ports with fixed priority.
- Same-cycle write-to-read bypass; per-register pending scoreboard for multi-cycle producers.
- Post-reset hardware clear sequencer. Register 0 is hard-wired zero. Sits between decode (RA/RW fields) and the ALU/writeback buses.

Parameters:
- DW, 32, data width of each register.
- DEPTH, 32, number of registers (power of 2, >= 4).
- AW, 5, address width, = log2(DEPTH).
- NRD, 2, number of read ports.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  synchronous active-low reset.
- RA  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- BusR  out  NRD*DW  read data, port i at bits [i*DW +: DW].
- BusyR  out  NRD  port i target register has a pending write.
- RW0, RW1  in  AW each  write addresses.
- BusW0, BusW1  in  DW each  write data.
- RegWr0, RegWr1  in  1 each  write enables.
- Issue  in  1  mark register IssueRW pending.
- IssueRW  in  AW  register being claimed by a multi-cycle producer.
- Ready  out  1  clear sequence done; file accepts writes and issues.

Behaviour:
- Reset (Rst_n=0 at posedge):
  - Enter INIT with clear pointer = 1 and all pending bits = 0.
  - Ready=0; BusR=0; BusyR=0 while Rst_n low.
- INIT state:
  - Each cycle writes 0 to entry[ptr], then ptr++.
  - After the cycle that clears entry DEPTH-1, go to RUN; Ready=1 from the next cycle.
  - INIT lasts exactly DEPTH-1 cycles after Rst_n deasserts.
  - RegWr0/RegWr1/Issue are ignored in INIT; BusR reads 0, BusyR reads 0.
- RUN state:
  - Writes: entry[RWk] <= BusWk at posedge when RegWrk=1 and RWk != 0.
  - If RW0 == RW1 with both enabled, port 1 wins; port 0 data is dropped.
  - Reads are combinational:
    - RA=0 gives 0.
    - Else, if RegWr1 && RW1==RA && RW1!=0, give BusW1.
    - Else, if RegWr0 && RW0==RA && RW0!=0, give BusW0.
    - Else give entry[RA].
    - This bypass gives zero read-after-write latency, replacing negedge-write timing.
  - Scoreboard:
    - A write via either port clears pending[RW] at posedge.
    - Issue sets pending[IssueRW] at posedge. Issue to reg 0 is ignored.
    - Set and clear to the same register in the same cycle: set wins (new producer claims it).
    - BusyR[i] = pending[RA_i] && !(same-cycle bypass hit on RA_i). It is 0 for RA=0.
- Reset mid-RUN: contents are re-cleared by a fresh INIT sweep, and all pending bits clear on the reset edge.
- There is no separate register for entry 0; it is never written or read from storage.
- Widths: all address compares are AW bits wide; no truncation of data.

Decomposition:
- Package regfile_pkg holds:
  - the state enum (INIT, RUN);
  - defaults for DW, DEPTH and NRD;
  - the ZERO_REG constant (0).
- Sub-module regfile_rdport, instantiated NRD times by generate. It holds the bypass mux and busy qualification for one port.
- Storage, write arbitration, scoreboard and the INIT FSM stay in the top module.

Test Plan:
- Reset/init: hold Rst_n=0 for 3 cycles, then release.
  - Ready rises exactly 31 cycles after the release edge.
  - Every RA reads 0.
  - RegWr0 to reg 5 with 0xDEAD during INIT has no effect; reg 5 reads 0 after Ready.
- Write/read/bypass: in RUN, RegWr0 RW0=7 BusW0=0x1234 with RA0=7 in the same cycle.
  - BusR port0 shows 0x1234 combinationally that cycle.
  - It still reads 0x1234 next cycle with RegWr0=0.
- Register zero: RegWr0 RW0=0 BusW0=0xFFFFFFFF, then RA0=0.
  - BusR=0 in both cycles.
  - Issue IssueRW=0 leaves BusyR=0.
- Write collision: RW0=RW1=9, BusW0=0xAAAA, BusW1=0x5555, both enabled.
  - Same-cycle read of 9 gives 0x5555.
  - Next-cycle read of 9 gives 0x5555.
- Scoreboard: Issue IssueRW=12, then RA1=12.
  - BusyR[1]=1 from the next cycle.
  - RegWr1 RW1=12 BusW1=0x42: BusyR[1]=0 that cycle (bypass) with BusR=0x42, and pending is cleared afterwards.
  - Same-cycle Issue and RegWr0 on reg 12 leaves pending=1.
- Mid-run reset: load reg 3 with 0x77 and Issue reg 4, then pulse Rst_n low for 1 cycle.
  - Ready=0 immediately and BusyR for reg 4 = 0.
  - After Ready returns, reg 3 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: same-cycle write bypass and busy qualification.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 5
) (
  input  logic          en,
  input  logic [AW-1:0] ra,
  input  logic [DW-1:0] stored,
  input  logic          pend,
  input  logic          wr0,
  input  logic [AW-1:0] rw0,
  input  logic [DW-1:0] data0,
  input  logic          wr1,
  input  logic [AW-1:0] rw1,
  input  logic [DW-1:0] data1,
  output logic [DW-1:0] data,
  output logic          busy
);

  logic hit0;
  logic hit1;

  // Port 1 bypass has priority over port 0, matching the write collision rule;
  // a bypass hit means the pending value is arriving this cycle, so not busy.
  always_comb begin
    hit0 = wr0 && (rw0 == ra) && (rw0 != AW'(ZERO_REG));
    hit1 = wr1 && (rw1 == ra) && (rw1 != AW'(ZERO_REG));
    data = '0;
    busy = 1'b0;
    if (en && (ra != AW'(ZERO_REG))) begin
      if (hit1)      data = data1;
      else if (hit0) data = data0;
      else           data = stored;
      busy = pend && !(hit0 || hit1);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NRD bypassed read
// ports, pending scoreboard and a post-reset clear sweep. Register 0 is zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = NRD_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NRD*AW-1:0] RA,
  output logic [NRD*DW-1:0] BusR,
  output logic [NRD-1:0]    BusyR,
  input  logic [AW-1:0]     RW0,
  input  logic [AW-1:0]     RW1,
  input  logic [DW-1:0]     BusW0,
  input  logic [DW-1:0]     BusW1,
  input  logic              RegWr0,
  input  logic              RegWr1,
  input  logic              Issue,
  input  logic [AW-1:0]     IssueRW,
  output logic              Ready
);

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     ptr;
  logic              clr_en;
  logic              run_en;
  logic              wr0_ok;
  logic              wr1_ok;
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  // Entry 0 has no storage: it is decoded as constant zero on the read side.
  logic [DW-1:0]     mem [1:DEPTH-1];

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  // Next state: leave INIT after the cycle that clears the last entry.
  always_comb begin
    state_nxt = state;
    if ((state == INIT) && (ptr == AW'(DEPTH - 1))) state_nxt = RUN;
  end

  // Outputs: everything is gated by Rst_n so reset takes effect immediately.
  always_comb begin
    clr_en = Rst_n && (state == INIT);
    run_en = Rst_n && (state == RUN);
    Ready  = run_en;
  end

  // Clear pointer starts at 1 because entry 0 has no storage.
  always_ff @(posedge Clk) begin
    if (!Rst_n)      ptr <= AW'(1);
    else if (clr_en) ptr <= ptr + 1'b1;
  end

  // Port 0 is suppressed on a same-address collision so port 1 wins.
  assign wr1_ok = run_en && RegWr1 && (RW1 != AW'(ZERO_REG));
  assign wr0_ok = run_en && RegWr0 && (RW0 != AW'(ZERO_REG)) &&
                  !(RegWr1 && (RW1 == RW0));

  // Storage: clear sweep during INIT, user writes during RUN (never both).
  always_ff @(posedge Clk) begin
    if (clr_en) mem[ptr] <= '0;
    if (wr0_ok) mem[RW0] <= BusW0;
    if (wr1_ok) mem[RW1] <= BusW1;
  end

  // Scoreboard update: writes clear, a new issue sets, and set wins on a tie.
  always_comb begin
    pending_nxt = pending;
    if (wr0_ok) pending_nxt[RW0] = 1'b0;
    if (wr1_ok) pending_nxt[RW1] = 1'b0;
    if (run_en && Issue && (IssueRW != AW'(ZERO_REG))) pending_nxt[IssueRW] = 1'b1;
  end

  // Scoreboard register: all claims are dropped on reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] stored;

    assign ra     = RA[i*AW +: AW];
    assign stored = (ra == AW'(ZERO_REG)) ? '0 : mem[ra];

    regfile_rdport #(
      .DW(DW),
      .AW(AW)
    ) u_rdport (
      .en    (run_en),
      .ra    (ra),
      .stored(stored),
      .pend  (pending[ra]),
      .wr0   (RegWr0),
      .rw0   (RW0),
      .data0 (BusW0),
      .wr1   (RegWr1),
      .rw1   (RW1),
      .data1 (BusW1),
      .data  (BusR[i*DW +: DW]),
      .busy  (BusyR[i])
    );
  end

endmodule
